grayscale_frame_ctrl: RTL and testbench

Frame-level controller that sequences the combinational `color_to_grayscale` datapath over one image. It accepts an RGB pixel stream under valid/ready, pushes each pixel through the converter, and registers the 10-bit result onto a valid/ready output stream. It tracks column and row position, flags line and frame ends, and reports frame completion. It sits between the pixel source (camera/frame-buffer reader) and the grayscale consumer.

---
 rtl/gray_ctrl_pkg.sv | 18 +
 rtl/color_to_grayscale.sv | 18 +
 rtl/grayscale_frame_ctrl.sv | 154 +++++++++++++++
 tb/tb_grayscale_frame_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_ctrl_pkg.sv
// gray_ctrl_pkg
// Shared widths, the frame-controller state encoding and the reset value of
// the running minimum used by grayscale_frame_ctrl and color_to_grayscale.
package gray_ctrl_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAY_W = 10;

  localparam logic [GRAY_W-1:0] STAT_MIN_INIT = 10'd1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/color_to_grayscale.sv
// color_to_grayscale
// Combinational luma approximation: gray = R + 2*G + B (range 0..1020).
// Ports:
//   r, g, b : in  PIX_W-bit colour components
//   gray    : out GRAY_W-bit result, never clamped
module color_to_grayscale
  import gray_ctrl_pkg::*;
(
  input  logic [PIX_W-1:0]  r,
  input  logic [PIX_W-1:0]  g,
  input  logic [PIX_W-1:0]  b,
  output logic [GRAY_W-1:0] gray
);

  // Widen before adding so the 10-bit sum cannot overflow.
  assign gray = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};

endmodule

// File: rtl/grayscale_frame_ctrl.sv
// grayscale_frame_ctrl
// Sequences one IMG_W x IMG_H frame of RGB pixels through color_to_grayscale
// and registers each result onto a single-entry valid/ready output stream,
// tagging line and frame ends.
// Optional build macro: GRAY_FRAME_STATS_EN enables per-frame min/max of the
// grayscale output; without it stat_min/stat_max are tied to 0.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, abort          : frame start pulse (IDLE only), frame cancel pulse
//   busy, done            : frame in progress (RUN/DRAIN), completion pulse
//   s_valid/s_ready/s_r/g/b : input pixel stream
//   m_valid/m_ready/m_gray/m_eol/m_eof : output grayscale stream
//   stat_min, stat_max    : frame statistics
//
// state | meaning
// IDLE  | waiting for start, counters held at 0
// RUN   | accepting pixels until the last pixel of the frame
// DRAIN | last pixel accepted, waiting for the output register to empty
// DONE  | one-cycle completion pulse
module grayscale_frame_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_r,
  input  logic [PIX_W-1:0]  s_g,
  input  logic [PIX_W-1:0]  s_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [GRAY_W-1:0] m_gray,
  output logic              m_eol,
  output logic              m_eof,
  output logic [GRAY_W-1:0] stat_min,
  output logic [GRAY_W-1:0] stat_max
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [GRAY_W-1:0] gray;
  logic              out_free;
  logic              accept;
  logic              col_last;
  logic              row_last;

  color_to_grayscale u_conv (
    .r    (s_r),
    .g    (s_g),
    .b    (s_b),
    .gray (gray)
  );

  // The output register can take a new pixel when empty or being drained now.
  assign out_free = !m_valid || m_ready;
  assign s_ready  = (state == RUN) && out_free;
  assign accept   = s_valid && s_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  assign busy = (state == RUN) || (state == DRAIN);
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign done = (state == DONE) && !abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !abort) state_nxt = RUN;
      RUN: begin
        if (abort)                                state_nxt = IDLE;
        else if (accept && col_last && row_last)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort)         state_nxt = IDLE;
        else if (out_free) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (abort || state == IDLE) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_gray  <= '0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
    end else if (abort) begin
      m_valid <= 1'b0;
    end else if (accept) begin
      m_valid <= 1'b1;
      m_gray  <= gray;
      m_eol   <= col_last;
      m_eof   <= col_last && row_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef GRAY_FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_min <= STAT_MIN_INIT;
      stat_max <= '0;
    end else if (abort || (state == IDLE && start)) begin
      stat_min <= STAT_MIN_INIT;
      stat_max <= '0;
    end else if (accept) begin
      if (gray < stat_min) stat_min <= gray;
      if (gray > stat_max) stat_max <= gray;
    end
  end
`else
  assign stat_min = '0;
  assign stat_max = '0;
`endif

endmodule

// File: tb/tb_grayscale_frame_ctrl.sv
module tb_grayscale_frame_ctrl;
  import gray_ctrl_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;
`ifdef GRAY_FRAME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b1;
  logic [7:0] s_r = '0, s_g = '0, s_b = '0;
  logic busy, done, s_ready, m_valid, m_eol, m_eof;
  logic [9:0] m_gray, stat_min, stat_max;

  logic start1 = 1'b0, abort1 = 1'b0, s_valid1 = 1'b0, m_ready1 = 1'b1;
  logic [7:0] s_r1 = '0, s_g1 = '0, s_b1 = '0;
  logic busy1, done1, s_ready1, m_valid1, m_eol1, m_eof1;
  logic [9:0] m_gray1, stat_min1, stat_max1;

  grayscale_frame_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_gray(m_gray), .m_eol(m_eol),
    .m_eof(m_eof), .stat_min(stat_min), .stat_max(stat_max)
  );

  grayscale_frame_ctrl #(.IMG_W(1), .IMG_H(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_r(s_r1), .s_g(s_g1), .s_b(s_b1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_gray(m_gray1), .m_eol(m_eol1),
    .m_eof(m_eof1), .stat_min(stat_min1), .stat_max(stat_max1)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  typedef struct { int gray; bit eol; bit eof; } exp_t;
  exp_t q[$];
  int   log_gray[$];
  bit   log_eol[$];
  bit   log_eof[$];
  bit   chk_en = 1'b0;
  bit   in_frame = 1'b0;
  bit   done_next = 1'b0;
  int   acc_cnt = 0;
  int   fmin = 1023, fmax = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      bit   exp_done, exp_sready, was_idle;
      exp_t e;
      exp_done   = done_next;
      was_idle   = !in_frame && !exp_done;
      exp_sready = in_frame && (acc_cnt < NPIX) && (q.size() == 0 || m_ready);

      chk("done", int'(done), int'(exp_done));
      chk("busy", int'(busy), int'(in_frame));
      chk("m_valid", int'(m_valid), int'(q.size() != 0));
      chk("s_ready", int'(s_ready), int'(exp_sready));
      if (q.size() != 0 && m_valid) begin
        chk("m_gray", int'(m_gray), q[0].gray);
        chk("m_eol", int'(m_eol), int'(q[0].eol));
        chk("m_eof", int'(m_eof), int'(q[0].eof));
      end
      if (exp_done) begin
        chk("stat_min@done", int'(stat_min), STATS ? fmin : 0);
        chk("stat_max@done", int'(stat_max), STATS ? fmax : 0);
      end

      done_next = 1'b0;
      if (q.size() != 0 && m_ready) begin
        e = q.pop_front();
        log_gray.push_back(e.gray);
        log_eol.push_back(e.eol);
        log_eof.push_back(e.eof);
        if (e.eof) begin
          in_frame  = 1'b0;
          done_next = 1'b1;
        end
      end
      if (s_valid && exp_sready && !abort) begin
        e.gray = int'(s_r) + 2 * int'(s_g) + int'(s_b);
        e.eol  = (acc_cnt % W) == W - 1;
        e.eof  = acc_cnt == NPIX - 1;
        q.push_back(e);
        acc_cnt++;
        if (e.gray < fmin) fmin = e.gray;
        if (e.gray > fmax) fmax = e.gray;
      end
      if (abort) begin
        q.delete();
        in_frame = 1'b0; done_next = 1'b0; acc_cnt = 0;
        fmin = 1023; fmax = 0;
      end else if (start && was_idle) begin
        in_frame = 1'b1; acc_cnt = 0;
        fmin = 1023; fmax = 0;
      end
      if (rst) begin
        q.delete();
        in_frame = 1'b0; done_next = 1'b0; acc_cnt = 0;
        fmin = 1023; fmax = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input int r, input int g, input int b);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_r = 8'(r); s_g = 8'(g); s_b = 8'(b);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    log_gray.delete(); log_eol.delete(); log_eof.delete();
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_eol"}, int'(m_eol), 0);
    chk({tag, "_m_eof"}, int'(m_eof), 0);
    chk({tag, "_m_gray"}, int'(m_gray), 0);
    chk({tag, "_stat_min"}, int'(stat_min), STATS ? 1023 : 0);
    chk({tag, "_stat_max"}, int'(stat_max), 0);
  endtask

  function automatic int count_eol();
    int n = 0;
    foreach (log_eol[i]) n += int'(log_eol[i]);
    return n;
  endfunction

  function automatic int count_eof();
    int n = 0;
    foreach (log_eof[i]) n += int'(log_eof[i]);
    return n;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    reset_vals("reset");
    @(posedge clk); #1;

    // Basic frame: (10,20,30) -> 80
    clear_log();
    pulse_start();
    for (int i = 0; i < NPIX; i++) send_pix(10, 20, 30);
    wait_done();
    chk("basic_count", log_gray.size(), 8);
    chk("basic_gray0", log_gray[0], 80);
    chk("basic_gray7", log_gray[7], 80);
    chk("basic_eol3", int'(log_eol[3]), 1);
    chk("basic_eol7", int'(log_eol[7]), 1);
    chk("basic_eol_cnt", count_eol(), 2);
    chk("basic_eof7", int'(log_eof[7]), 1);
    chk("basic_eof_cnt", count_eof(), 1);

    // Backpressure: pixels (9k,9k,9k) -> 36k, stall after the first output
    clear_log();
    pulse_start();
    send_pix(9, 9, 9);
    m_ready = 1'b0;
    s_valid = 1'b1; s_r = 8'd18; s_g = 8'd18; s_b = 8'd18;
    repeat (3) begin
      @(negedge clk);
      chk("bp_s_ready", int'(s_ready), 0);
      chk("bp_m_gray", int'(m_gray), 36);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 2; i <= NPIX; i++) send_pix(9 * i, 9 * i, 9 * i);
    wait_done();
    chk("bp_count", log_gray.size(), 8);
    chk("bp_gray0", log_gray[0], 36);
    chk("bp_gray1", log_gray[1], 72);
    chk("bp_gray7", log_gray[7], 288);

    // Extremes
    clear_log();
    pulse_start();
    send_pix(255, 255, 255);
    send_pix(0, 0, 0);
    for (int i = 2; i < NPIX; i++) send_pix(1, 2, 3);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (done) ok = 1'b1;
      end
      chk("ext_done_seen", int'(ok), 1);
      chk("ext_stat_max", int'(stat_max), STATS ? 1020 : 0);
      chk("ext_stat_min", int'(stat_min), STATS ? 0 : 0);
      @(posedge clk); #1;
    end
    chk("ext_gray0", log_gray[0], 1020);
    chk("ext_gray1", log_gray[1], 0);
    chk("ext_gray2", log_gray[2], 8);

    // Abort after 3 accepted pixels
    pulse_start();
    for (int i = 0; i < 3; i++) send_pix(3, 3, 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_m_valid", int'(m_valid), 0);
    @(posedge clk); #1;
    clear_log();
    pulse_start();
    for (int i = 0; i < NPIX; i++) send_pix(5, 5, 5);
    wait_done();
    chk("abort_restart_eol2", int'(log_eol[2]), 0);
    chk("abort_restart_eol3", int'(log_eol[3]), 1);
    chk("abort_restart_gray", log_gray[3], 20);

    // start during RUN is ignored
    clear_log();
    pulse_start();
    send_pix(1, 1, 1);
    send_pix(2, 2, 2);
    pulse_start();
    for (int i = 2; i < NPIX; i++) send_pix(4, 0, 4);
    wait_done();
    chk("run_start_count", log_gray.size(), 8);
    chk("run_start_eof_cnt", count_eof(), 1);

    // start+abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", int'(busy), 0);
    chk("sa_s_ready", int'(s_ready), 0);
    @(posedge clk); #1;

    // rst mid-frame with a full output register
    pulse_start();
    for (int i = 0; i < 3; i++) send_pix(7, 7, 7);
    m_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    reset_vals("midrst");
    @(posedge clk); #1;
    m_ready = 1'b1;

    // Degenerate 1x1 frame
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    s_valid1 = 1'b1; s_r1 = 8'd1; s_g1 = 8'd1; s_b1 = 8'd1;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (s_ready1) ok = 1'b1;
      end
      chk("deg_accept", int'(ok), 1);
    end
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    @(negedge clk);
    chk("deg_m_valid", int'(m_valid1), 1);
    chk("deg_m_gray", int'(m_gray1), 4);
    chk("deg_m_eol", int'(m_eol1), 1);
    chk("deg_m_eof", int'(m_eof1), 1);
    @(negedge clk);
    chk("deg_done", int'(done1), 1);
    chk("deg_m_valid_after", int'(m_valid1), 0);
    @(negedge clk);
    chk("deg_done_one_cycle", int'(done1), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
